// File: rtl/array_alloc_pkg.sv
// rtl/array_alloc_pkg.sv - shared types and defaults for the array-handle allocator
package array_alloc_pkg;

    localparam int MEW_DEFAULT = 12;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } op_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/array_allocator_rr_arbiter.sv
// rtl/array_allocator_rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr_i wins
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          any_o
);

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        // Outer loop is the circular distance from the pointer, so the first hit is the winner.
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!any_o && req_i[i] && (i == ((int'(ptr_i) + off) % N))) begin
                    any_o       = 1'b1;
                    grant_o[i]  = 1'b1;
                    grant_idx_o = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/array_allocator.sv
// rtl/array_allocator.sv - arbitrated array-handle allocator with size table, free stack and query port
module array_allocator
    import array_alloc_pkg::*;
#(
    parameter int MemoryElementWidth = MEW_DEFAULT,
    parameter int NArrays            = 4,
    parameter int NRequesters        = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NRequesters-1:0]                 reqValid,
    input  logic [NRequesters-1:0]                 reqOp,
    input  logic [NRequesters*MemoryElementWidth-1:0] reqArray,
    output logic [NRequesters-1:0]                 ack,
    output logic [MemoryElementWidth-1:0]          ackArray,
    output logic                                   ackError,
    input  logic                                   lenValid,
    input  logic [MemoryElementWidth-1:0]          lenArray,
    input  logic [MemoryElementWidth-1:0]          lenIndex,
    input  logic [MemoryElementWidth-1:0]          qArray,
    output logic [MemoryElementWidth-1:0]          qSize,
    output logic [MemoryElementWidth-1:0]          allocs,
    output logic [MemoryElementWidth-1:0]          freeTop
);

    localparam int W  = MemoryElementWidth;
    localparam int PW = (NRequesters > 1) ? $clog2(NRequesters) : 1;

    state_e                 state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NRequesters-1:0] ack_q, ack_d;
    logic [W-1:0]           ack_array_q, ack_array_d;
    logic                   ack_error_q, ack_error_d;
    logic [W-1:0]           q_size_q, q_size_d;
    logic [W-1:0]           allocs_q, allocs_d;
    logic [W-1:0]           free_top_q, free_top_d;
    logic [NArrays-1:0]     in_use_q, in_use_d;
    logic [W-1:0]           size_q [NArrays];
    logic [W-1:0]           size_d [NArrays];
    logic [W-1:0]           stack_q [NArrays];
    logic [W-1:0]           stack_d [NArrays];

    logic [NRequesters-1:0] grant;
    logic [PW-1:0]          grant_idx;
    logic                   grant_any;

    op_e                    sel_op;
    logic [W-1:0]           sel_array;
    logic                   sel_in_use;
    logic [W-1:0]           stack_top;
    logic [W-1:0]           handle;
    logic                   do_alloc;
    logic [W:0]             len_next;

    rr_arbiter #(
        .N  (NRequesters),
        .PW (PW)
    ) u_arb (
        .req_i       (reqValid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        ack_array_d = ack_array_q;
        ack_error_d = ack_error_q;
        allocs_d    = allocs_q;
        free_top_d  = free_top_q;
        in_use_d    = in_use_q;
        size_d      = size_q;
        stack_d     = stack_q;
        sel_op      = OP_ALLOC;
        sel_array   = '0;
        sel_in_use  = 1'b0;
        stack_top   = '0;
        handle      = '0;
        do_alloc    = 1'b0;
        len_next    = '0;
        q_size_d    = '0;

        for (int i = 0; i < NRequesters; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_op    = op_e'(reqOp[i]);
                sel_array = reqArray[i*W +: W];
            end
        end
        for (int i = 0; i < NArrays; i++) begin
            if (free_top_q == W'(i + 1)) stack_top = stack_q[i];
            if (sel_array == W'(i))      sel_in_use = in_use_q[i];
            if (qArray == W'(i))         q_size_d = size_q[i];
        end

        // Length growth runs before the op so a same-cycle allocate clear overrides it.
        if (lenValid) begin
            len_next = {1'b0, lenIndex} + 1'b1;
            for (int i = 0; i < NArrays; i++) begin
                if (lenArray == W'(i) && in_use_q[i] && ({1'b0, size_q[i]} < len_next)) begin
                    size_d[i] = len_next[W] ? {W{1'b1}} : len_next[W-1:0];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ack_d       = grant;
                    state_d     = SERVE;
                    rr_ptr_d    = (grant_idx == PW'(NRequesters - 1)) ? '0 : grant_idx + 1'b1;
                    ack_error_d = 1'b0;
                    if (sel_op == OP_ALLOC) begin
                        if (free_top_q != '0) begin
                            handle     = stack_top;
                            free_top_d = free_top_q - 1'b1;
                            do_alloc   = 1'b1;
                        end else if (allocs_q < W'(NArrays)) begin
                            handle   = allocs_q;
                            allocs_d = allocs_q + 1'b1;
                            do_alloc = 1'b1;
                        end else begin
                            ack_error_d = 1'b1;
                            ack_array_d = '0;
                        end
                        if (do_alloc) begin
                            ack_array_d = handle;
                            for (int i = 0; i < NArrays; i++) begin
                                if (handle == W'(i)) begin
                                    in_use_d[i] = 1'b1;
                                    size_d[i]   = '0;
                                end
                            end
                        end
                    end else begin
                        if (sel_array >= allocs_q || !sel_in_use) begin
                            ack_error_d = 1'b1;
                            ack_array_d = '0;
                        end else begin
                            ack_array_d = sel_array;
                            free_top_d  = free_top_q + 1'b1;
                            for (int i = 0; i < NArrays; i++) begin
                                if (free_top_q == W'(i)) stack_d[i] = sel_array;
                                if (sel_array == W'(i))  in_use_d[i] = 1'b0;
                            end
                        end
                    end
                end
            end
            SERVE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            ack_array_q <= '0;
            ack_error_q <= 1'b0;
            q_size_q    <= '0;
            allocs_q    <= '0;
            free_top_q  <= '0;
            in_use_q    <= '0;
            for (int i = 0; i < NArrays; i++) begin
                size_q[i]  <= '0;
                stack_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            ack_array_q <= ack_array_d;
            ack_error_q <= ack_error_d;
            q_size_q    <= q_size_d;
            allocs_q    <= allocs_d;
            free_top_q  <= free_top_d;
            in_use_q    <= in_use_d;
            size_q      <= size_d;
            stack_q     <= stack_d;
        end
    end

    assign ack      = ack_q;
    assign ackArray = ack_array_q;
    assign ackError = ack_error_q;
    assign qSize    = q_size_q;
    assign allocs   = allocs_q;
    assign freeTop  = free_top_q;

endmodule
